// File: rtl/if_id_if.sv
// Fetch-to-decode handshake bundle: fetch side pushes {pc, instruction},
// decode side pops the head; queue status travels back to the fetch side.
interface if_id_if #(
  parameter int CW = 3
);
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_instruction;
  logic          flush;
  logic          id_ready;
  logic          freeze;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_instruction;
  logic [CW-1:0] count;
  logic [15:0]   flush_cnt;

  modport master (
    output if_valid, if_pc, if_instruction, flush, id_ready,
    input  freeze, id_valid, id_pc, id_instruction, count, flush_cnt
  );

  modport slave (
    input  if_valid, if_pc, if_instruction, flush, id_ready,
    output freeze, id_valid, id_pc, id_instruction, count, flush_cnt
  );
endinterface

// File: rtl/if_id_queue.sv
// Circular instruction queue between fetch and decode. Occupancy alone marks
// validity, so the storage array carries no reset.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic     clk,
  input logic     rst,
  if_id_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic [15:0]   fcnt;
  logic          push, pop;

  assign bus.freeze         = (cnt == CW'(DEPTH));
  assign bus.id_valid       = (cnt != '0) & ~bus.flush;
  assign push               = bus.if_valid & ~bus.freeze & ~bus.flush;
  assign pop                = bus.id_valid & bus.id_ready;
  assign bus.id_pc          = pc_mem[rd_ptr];
  assign bus.id_instruction = ins_mem[rd_ptr];
  assign bus.count          = cnt;
  assign bus.flush_cnt      = fcnt;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= bus.if_pc;
      ins_mem[wr_ptr] <= bus.if_instruction;
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so natural overflow is the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      fcnt   <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      if (fcnt != 16'hFFFF) fcnt <= fcnt + 16'd1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule
